bram_sdp: RTL and testbench

- Parametrised simple-dual-port block RAM: one write port and one read port on a single clock.
- Successor to the single-port 8-bit image/coefficient store, adding:
  - generic width and depth
  - byte-granular write enables
  - optional output register
  - selectable read-during-write behaviour
  - read-valid tracking
  - a hardware clear engine
- Sits between the image/weight loaders and the convolution datapath; line and weight buffers are instantiated from it.

---
 rtl/cnn_mem_pkg.sv | 22 ++
 rtl/bram_clear_ctrl.sv | 62 ++++++
 rtl/bram_sdp.sv | 154 +++++++++++++++
 tb/tb_bram_sdp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mem_pkg.sv
// Shared constants, clear-FSM state type and sizing helper for the CNN line/weight buffers.
// No logic of its own; consumed at elaboration by bram_sdp and bram_clear_ctrl.
// Not applicable: no ports, no flow control.
package cnn_mem_pkg;

  // Read-during-write selection for a same-address collision.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Clear sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Number of write-enable lanes in a data word.
  function automatic int num_bytes(input int ram_width, input int byte_width);
    return ram_width / byte_width;
  endfunction

endpackage

// File: rtl/bram_clear_ctrl.sv
// Clear sweep engine: walks every implemented address once, writing the clear word.
// Latency: busy rises the cycle after clear_start, lasts RAM_DEPTH cycles, then one clear_done cycle.
// Backpressure: none; while busy the owner must steer the RAM write port from clr_we_o/clr_addr_o.
module bram_clear_ctrl
  import cnn_mem_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 16,
  parameter int RAM_DEPTH     = 2**RAM_ADDR_BITS
)(
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     clear_start_i,
  output logic                     clr_we_o,
  output logic [RAM_ADDR_BITS-1:0] clr_addr_o,
  output logic                     busy_o,
  output logic                     clear_done_o
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_DEPTH - 1);

  clr_state_e                 state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]   ptr_q, ptr_d;

  // State and sweep pointer registers; reset abandons any sweep in progress.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: start only from IDLE, advance one address per cycle, flag completion once.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_start_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q == CLEAR);
  assign clr_we_o     = (state_q == CLEAR);
  assign clr_addr_o   = ptr_q;
  assign clear_done_o = (state_q == DONE);

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM with byte write enables, collision bypass, clear engine and read-valid tracking.
// Latency: read data and rd_valid appear 1 + OUTPUT_REG cycles after an accepted read.
// Backpressure: none; reads and external writes are dropped (not stalled) while the clear engine is busy.
module bram_sdp
  import cnn_mem_pkg::*;
#(
  parameter int                   RAM_WIDTH     = 8,
  parameter int                   RAM_ADDR_BITS = 16,
  parameter int                   RAM_DEPTH     = 2**RAM_ADDR_BITS,
  parameter int                   BYTE_WIDTH    = 8,
  parameter int                   OUTPUT_REG    = 0,
  parameter int                   RDW_MODE      = RDW_OLD,
  parameter string                DATA_FILE     = "",
  parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0,
  localparam int                  NUM_BYTES     = num_bytes(RAM_WIDTH, BYTE_WIDTH)
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_enable,
  input  logic [NUM_BYTES-1:0]     wr_byte_en,
  input  logic [RAM_ADDR_BITS-1:0] wr_address,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  input  logic                     rd_enable,
  input  logic [RAM_ADDR_BITS-1:0] rd_address,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     rd_valid,
  input  logic                     clear_start,
  output logic                     busy,
  output logic                     clear_done
);

  // Index width covers exactly the implemented words; range checks use one extra bit so a
  // full-size RAM_DEPTH of 2**RAM_ADDR_BITS is representable.
  localparam int                     IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [RAM_ADDR_BITS:0] DEPTH_EXT = (RAM_ADDR_BITS + 1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                     clr_we;
  logic [RAM_ADDR_BITS-1:0] clr_addr;

  logic                     wr_en_mux;
  logic [NUM_BYTES-1:0]     wr_be_mux;
  logic [RAM_ADDR_BITS-1:0] wr_addr_mux;
  logic [RAM_WIDTH-1:0]     wr_data_mux;
  logic                     wr_fire;
  logic [IDX_W-1:0]         wr_idx;

  logic                     rd_accept;
  logic                     rd_in_range;
  logic [IDX_W-1:0]         rd_idx;
  logic [RAM_WIDTH-1:0]     s1_dat_q, s1_dat_d;
  logic                     s1_vld_q;

  bram_clear_ctrl #(
    .RAM_ADDR_BITS (RAM_ADDR_BITS),
    .RAM_DEPTH     (RAM_DEPTH)
  ) u_clear_ctrl (
    .clock_i       (clock),
    .reset_i       (reset),
    .clear_start_i (clear_start),
    .clr_we_o      (clr_we),
    .clr_addr_o    (clr_addr),
    .busy_o        (busy),
    .clear_done_o  (clear_done)
  );

  // Write-port steering: the clear engine owns the port for the whole sweep.
  always_comb begin
    wr_en_mux   = wr_enable;
    wr_be_mux   = wr_byte_en;
    wr_addr_mux = wr_address;
    wr_data_mux = wr_data;
    if (clr_we) begin
      wr_en_mux   = 1'b1;
      wr_be_mux   = '1;
      wr_addr_mux = clr_addr;
      wr_data_mux = CLEAR_VALUE;
    end
  end

  // Addresses beyond the implemented depth never touch the array.
  assign wr_fire = wr_en_mux && ({1'b0, wr_addr_mux} < DEPTH_EXT);
  assign wr_idx  = wr_addr_mux[IDX_W-1:0];

  // Byte-lane writes; memory contents deliberately carry no reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be_mux[i]) begin
          mem_q[wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_mux[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign rd_accept   = rd_enable && !busy;
  assign rd_in_range = ({1'b0, rd_address} < DEPTH_EXT);
  assign rd_idx      = rd_address[IDX_W-1:0];

  // Read word: zero when out of range; in new-data mode, enabled lanes of a same-address write
  // bypass the array so the read sees them this cycle.
  always_comb begin
    s1_dat_d = '0;
    if (rd_in_range) begin
      s1_dat_d = mem_q[rd_idx];
      if (RDW_MODE == RDW_NEW && wr_fire && wr_addr_mux == rd_address) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wr_be_mux[i]) begin
            s1_dat_d[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_mux[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // First read stage: data register only loads on an accepted read, so it holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= rd_accept;
      if (rd_accept) begin
        s1_dat_q <= s1_dat_d;
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                 s2_vld_q;
    logic [RAM_WIDTH-1:0] s2_dat_q;

    // Output register stage: forwards a valid word one cycle later and holds between reads.
    always_ff @(posedge clock) begin
      if (reset) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_dat_q <= s1_dat_q;
        end
      end
    end

    assign rd_data  = s2_dat_q;
    assign rd_valid = s2_vld_q;
  end else begin : g_noreg
    assign rd_data  = s1_dat_q;
    assign rd_valid = s1_vld_q;
  end

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: four differently parameterised instances driven side by side.
// A behavioural model (word arrays, clear countdown, due-cycle table) predicts every output each cycle.
// Directed steps cover the listed scenarios, followed by a randomized soak.
module tb_bram_sdp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       we, rde, cs;
  logic [3:0][3:0]  be;
  logic [3:0][7:0]  wa, ra;
  logic [3:0][31:0] wd;
  logic [31:0]      rd0, rd1;
  logic [7:0]       rd2, rd3;
  logic [3:0]       rv, bz, dn;

  // Per-instance configuration as seen by the model.
  int          DEP  [4] = '{256, 256, 16, 12};
  int          LATC [4] = '{1, 2, 1, 2};
  int          RDWC [4] = '{0, 1, 0, 1};
  int          NBC  [4] = '{4, 4, 1, 1};
  int          AM   [4] = '{255, 255, 15, 15};
  logic [31:0] CVC  [4] = '{32'h0, 32'h5A5A0F0F, 32'hA5, 32'h3C};

  bram_sdp #(.RAM_WIDTH(32), .RAM_ADDR_BITS(8), .RAM_DEPTH(256), .OUTPUT_REG(0),
             .RDW_MODE(0), .CLEAR_VALUE(32'h0)) u0 (
    .clock(clk), .reset(rst), .wr_enable(we[0]), .wr_byte_en(be[0]), .wr_address(wa[0]),
    .wr_data(wd[0]), .rd_enable(rde[0]), .rd_address(ra[0]), .rd_data(rd0), .rd_valid(rv[0]),
    .clear_start(cs[0]), .busy(bz[0]), .clear_done(dn[0]));

  bram_sdp #(.RAM_WIDTH(32), .RAM_ADDR_BITS(8), .RAM_DEPTH(256), .OUTPUT_REG(1),
             .RDW_MODE(1), .CLEAR_VALUE(32'h5A5A0F0F)) u1 (
    .clock(clk), .reset(rst), .wr_enable(we[1]), .wr_byte_en(be[1]), .wr_address(wa[1]),
    .wr_data(wd[1]), .rd_enable(rde[1]), .rd_address(ra[1]), .rd_data(rd1), .rd_valid(rv[1]),
    .clear_start(cs[1]), .busy(bz[1]), .clear_done(dn[1]));

  bram_sdp #(.RAM_WIDTH(8), .RAM_ADDR_BITS(4), .RAM_DEPTH(16), .OUTPUT_REG(0),
             .RDW_MODE(0), .CLEAR_VALUE(8'hA5)) u2 (
    .clock(clk), .reset(rst), .wr_enable(we[2]), .wr_byte_en(be[2][0:0]), .wr_address(wa[2][3:0]),
    .wr_data(wd[2][7:0]), .rd_enable(rde[2]), .rd_address(ra[2][3:0]), .rd_data(rd2), .rd_valid(rv[2]),
    .clear_start(cs[2]), .busy(bz[2]), .clear_done(dn[2]));

  bram_sdp #(.RAM_WIDTH(8), .RAM_ADDR_BITS(4), .RAM_DEPTH(12), .OUTPUT_REG(1),
             .RDW_MODE(1), .CLEAR_VALUE(8'h3C)) u3 (
    .clock(clk), .reset(rst), .wr_enable(we[3]), .wr_byte_en(be[3][0:0]), .wr_address(wa[3][3:0]),
    .wr_data(wd[3][7:0]), .rd_enable(rde[3]), .rd_address(ra[3][3:0]), .rd_data(rd3), .rd_valid(rv[3]),
    .clear_start(cs[3]), .busy(bz[3]), .clear_done(dn[3]));

  // Model state.
  logic [31:0] mm [4][256];
  int          busy_left [4];
  int          ptr [4];
  bit          done_m [4];
  bit          ev [4][4];
  logic [31:0] ed [4][4];
  logic [31:0] last [4];
  int          cyc;
  int          n_cmp, n_bad;

  function automatic logic [31:0] rdk(input int k);
    case (k)
      0:       return rd0;
      1:       return rd1;
      2:       return {24'h0, rd2};
      default: return {24'h0, rd3};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply the pre-edge inputs to the model, take the edge, compare every output.
  task automatic tick();
    logic [31:0] rv_m;
    bit          b, was_done;
    int          ri, wi;
    for (int k = 0; k < 4; k++) begin
      b        = busy_left[k] > 0;
      was_done = done_m[k];
      done_m[k] = 1'b0;
      ri = int'(ra[k]) & AM[k];
      wi = int'(wa[k]) & AM[k];
      if (b) begin
        mm[k][ptr[k]] = CVC[k];
        ptr[k]++;
        busy_left[k]--;
        if (busy_left[k] == 0) done_m[k] = 1'b1;
      end else begin
        if (!rst && rde[k]) begin
          rv_m = 32'h0;
          if (ri < DEP[k]) begin
            rv_m = mm[k][ri];
            if (RDWC[k] == 1 && we[k] && wi == ri)
              for (int i = 0; i < NBC[k]; i++)
                if (be[k][i]) rv_m[i*8 +: 8] = wd[k][i*8 +: 8];
          end
          ev[k][(cyc + LATC[k]) % 4] = 1'b1;
          ed[k][(cyc + LATC[k]) % 4] = rv_m;
        end
        if (we[k] && wi < DEP[k])
          for (int i = 0; i < NBC[k]; i++)
            if (be[k][i]) mm[k][wi][i*8 +: 8] = wd[k][i*8 +: 8];
        if (cs[k] && !was_done) begin
          busy_left[k] = DEP[k];
          ptr[k] = 0;
        end
      end
      if (rst) begin
        busy_left[k] = 0;
        done_m[k] = 1'b0;
        last[k] = 32'h0;
        for (int j = 0; j < 4; j++) ev[k][j] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (ev[k][cyc % 4]) begin
        chk($sformatf("k%0d_rd_valid", k), {31'h0, rv[k]}, 32'h1);
        chk($sformatf("k%0d_rd_data", k), rdk(k), ed[k][cyc % 4]);
        last[k] = ed[k][cyc % 4];
        ev[k][cyc % 4] = 1'b0;
      end else begin
        chk($sformatf("k%0d_rd_valid_idle", k), {31'h0, rv[k]}, 32'h0);
        chk($sformatf("k%0d_rd_data_hold", k), rdk(k), last[k]);
      end
      chk($sformatf("k%0d_busy", k), {31'h0, bz[k]}, {31'h0, busy_left[k] > 0});
      chk($sformatf("k%0d_clear_done", k), {31'h0, dn[k]}, {31'h0, done_m[k]});
    end
  endtask

  task automatic wr(input int k, input int a, input logic [31:0] d, input logic [3:0] m);
    we[k] = 1'b1; wa[k] = 8'(a); wd[k] = d; be[k] = m;
    tick();
    we[k] = 1'b0; be[k] = 4'h0;
  endtask

  // Read one word and compare against a literal at the expected latency.
  task automatic rd_lit(input int k, input int a, input logic [31:0] exp, input string tag);
    ra[k] = 8'(a); rde[k] = 1'b1;
    tick();
    rde[k] = 1'b0;
    if (LATC[k] == 2) begin
      chk({tag, "_early"}, {31'h0, rv[k]}, 32'h0);
      tick();
    end
    chk({tag, "_vld"}, {31'h0, rv[k]}, 32'h1);
    chk({tag, "_dat"}, rdk(k), exp);
  endtask

  int nb, nd;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; we = '0; rde = '0; cs = '0; be = '0; wa = '0; ra = '0; wd = '0;
    for (int k = 0; k < 4; k++) begin
      busy_left[k] = 0; ptr[k] = 0; done_m[k] = 1'b0; last[k] = 32'h0;
      for (int j = 0; j < 4; j++) ev[k][j] = 1'b0;
    end

    // Reset state.
    tick();
    tick();
    chk("reset_rd_valid", {28'h0, rv}, 32'h0);
    chk("reset_busy", {28'h0, bz}, 32'h0);
    chk("reset_rd_data0", rd0, 32'h0);
    rst = 1'b0;

    // Sweep every instance so the model knows all contents.
    cs = 4'hF;
    tick();
    cs = 4'h0;
    repeat (260) tick();

    // Basic read: write then read the next cycle.
    wr(0, 'h10, 32'hDEADBEEF, 4'hF);
    rd_lit(0, 'h10, 32'hDEADBEEF, "basic_read");

    // Byte mask with output register.
    wr(1, 'h20, 32'h11223344, 4'hF);
    wr(1, 'h20, 32'hAABBCCDD, 4'b0101);
    rd_lit(1, 'h20, 32'h11BB33DD, "byte_mask");
    wr(1, 'h21, 32'h21212121, 4'hF);
    wr(1, 'h22, 32'h22222222, 4'hF);
    rde[1] = 1'b1;
    ra[1] = 8'h20; tick();
    ra[1] = 8'h21; tick();
    chk("b2b_first_vld", {31'h0, rv[1]}, 32'h1);
    chk("b2b_first_dat", rd1, 32'h11BB33DD);
    ra[1] = 8'h22; tick();
    rde[1] = 1'b0;
    chk("b2b_second_dat", rd1, 32'h21212121);
    tick();
    chk("b2b_third_vld", {31'h0, rv[1]}, 32'h1);
    chk("b2b_third_dat", rd1, 32'h22222222);
    tick();
    chk("b2b_after_vld", {31'h0, rv[1]}, 32'h0);

    // Same-cycle collision on both read-during-write modes.
    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b1; wa[k] = 8'h05; wd[k] = 32'h0; be[k] = 4'hF;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      wd[k] = 32'hFFFFFFFF; be[k] = 4'b1100; rde[k] = 1'b1; ra[k] = 8'h05;
    end
    tick();
    we[1:0] = 2'b00; rde[1:0] = 2'b00; be[0] = 4'h0; be[1] = 4'h0;
    chk("rdw_old", rd0, 32'h00000000);
    tick();
    chk("rdw_new", rd1, 32'hFFFF0000);
    rd_lit(0, 'h05, 32'hFFFF0000, "rdw_followup");

    // Clear sweep with a write attempted during busy.
    wr(2, 3, 32'h11, 4'h1);
    cs[2] = 1'b1;
    tick();
    cs[2] = 1'b0;
    nb = int'(bz[2]); nd = int'(dn[2]);
    for (int t = 0; t < 30; t++) begin
      if (t == 2) begin
        we[2] = 1'b1; wa[2] = 8'h03; wd[2] = 32'h5E; be[2] = 4'h1;
      end
      tick();
      we[2] = 1'b0;
      nb += int'(bz[2]); nd += int'(dn[2]);
    end
    chk("sweep_busy_cycles", 32'(nb), 32'd16);
    chk("sweep_done_pulses", 32'(nd), 32'd1);
    for (int a = 0; a < 16; a++) rd_lit(2, a, 32'hA5, $sformatf("swept_%0d", a));

    // Reset during the sixth busy cycle.
    wr(2, 10, 32'h3B, 4'h1);
    cs[2] = 1'b1;
    tick();
    cs[2] = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midclr_busy", {31'h0, bz[2]}, 32'h0);
    chk("midclr_done", {31'h0, dn[2]}, 32'h0);
    nd = 0;
    repeat (20) begin tick(); nd += int'(dn[2]); end
    chk("midclr_no_done", 32'(nd), 32'd0);
    for (int a = 0; a < 5; a++) rd_lit(2, a, 32'hA5, $sformatf("partial_%0d", a));
    rd_lit(2, 10, 32'h3B, "partial_kept");

    // Out of range on the 12-word instance.
    wr(3, 13, 32'h77, 4'h1);
    rd_lit(3, 13, 32'h0, "oor_read");
    rd_lit(3, 0, 32'h3C, "oor_addr0");

    // Clear start and write together: the sweep overwrites the write.
    we[3] = 1'b1; wa[3] = 8'h02; wd[3] = 32'h99; be[3] = 4'h1; cs[3] = 1'b1;
    tick();
    we[3] = 1'b0; cs[3] = 1'b0;
    repeat (14) tick();
    rd_lit(3, 2, 32'h3C, "start_with_write");

    // Randomized soak checked against the model every cycle.
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 4; k++) begin
        we[k]  = 1'($urandom_range(0, 1));
        rde[k] = 1'($urandom_range(0, 1));
        wa[k]  = 8'($urandom_range(0, 15));
        ra[k]  = 8'($urandom_range(0, 15));
        be[k]  = 4'($urandom);
        wd[k]  = $urandom;
        cs[k]  = ($urandom_range(0, 199) == 0);
      end
      tick();
    end
    we = '0; rde = '0; cs = '0;
    repeat (270) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
